// File: rtl/cic_pkg.sv
// cic_pkg: shared types, constants and width helper for the PDM CIC decimator.
package cic_pkg;
  typedef enum logic [1:0] {IDLE, COMB, OUT} cic_state_e;
  localparam logic PDM_POS_BIT = 1'b1;
  function automatic int cic_acc_width(input int order, input int dec);
    return order * $clog2(dec) + 2;
  endfunction
endpackage

// File: rtl/cic_comb_engine.sv
// cic_comb_engine: snapshots integrator outputs on tick, runs the comb chain one channel per cycle, scales/saturates, strobes all channels together.
module cic_comb_engine
  import cic_pkg::*;
#(
  parameter int N_CH  = 2,
  parameter int ORDER = 4,
  parameter int OUT_W = 16,
  parameter int W     = 26
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic [N_CH*W-1:0]     last,
  output logic                  busy,
  output logic [N_CH*OUT_W-1:0] pcm,
  output logic                  pcm_valid
);
  localparam int S   = W - 1 - OUT_W;
  localparam int CHW = N_CH > 1 ? $clog2(N_CH) : 1;
  localparam logic signed [W-1:0] HI = W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [W-1:0] LO = ~HI;
`ifdef CIC_ROUND_EN
  localparam logic [W-1:0] HALF = W'((1 << S) >> 1);
`else
  localparam logic [W-1:0] HALF = '0;
`endif
  cic_state_e state_q, state_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [N_CH*W-1:0] snap_q, snap_d;
  logic [W-1:0] dly_q [N_CH][ORDER];
  logic [W-1:0] dly_d [N_CH][ORDER];
  logic [W-1:0] diff [ORDER+1];
  logic signed [W-1:0] sh;
  logic [OUT_W-1:0] res_q [N_CH];
  logic [OUT_W-1:0] res_d [N_CH];
  logic [OUT_W-1:0] sat;
  logic [N_CH*OUT_W-1:0] pcm_q, pcm_d;
  always_comb begin
    diff[0] = snap_q[ch_q*W +: W];
    for (int k = 0; k < ORDER; k++) diff[k+1] = diff[k] - dly_q[ch_q][k];
    sh = $signed(diff[ORDER] + HALF) >>> S;
    sat = (sh > HI) ? HI[OUT_W-1:0] : (sh < LO) ? LO[OUT_W-1:0] : sh[OUT_W-1:0];
  end
  always_comb begin
    state_d = state_q;
    ch_d = ch_q;
    snap_d = snap_q;
    dly_d = dly_q;
    res_d = res_q;
    pcm_d = pcm_q;
    if (state_q == IDLE && tick) begin
      snap_d = last;
      ch_d = '0;
      state_d = COMB;
    end
    if (state_q == COMB) begin
      for (int k = 0; k < ORDER; k++) dly_d[ch_q][k] = diff[k];
      res_d[ch_q] = sat;
      ch_d = ch_q + 1'b1;
      if (ch_q == CHW'(N_CH - 1)) begin
        state_d = OUT;
        for (int c = 0; c < N_CH; c++) pcm_d[c*OUT_W +: OUT_W] = res_d[c];
      end
    end
    if (state_q == OUT) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ch_q <= '0;
      snap_q <= '0;
      dly_q <= '{default: '0};
      res_q <= '{default: '0};
      pcm_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      snap_q <= snap_d;
      dly_q <= dly_d;
      res_q <= res_d;
      pcm_q <= pcm_d;
    end
  end
  assign busy = state_q != IDLE;
  assign pcm_valid = state_q == OUT;
  assign pcm = pcm_q;
endmodule

// File: rtl/pdm_cic_decimator.sv
// pdm_cic_decimator: N_CH PDM streams -> CIC integrate, decimate by DEC, time-multiplexed comb -> signed PCM.
// Define CIC_ROUND_EN for round-half-up output scaling instead of floor.
module pdm_cic_decimator
  import cic_pkg::*;
#(
  parameter int N_CH  = 2,
  parameter int ORDER = 4,
  parameter int DEC   = 64,
  parameter int OUT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       pdm,
  input  logic                  pdm_valid,
  output logic [N_CH*OUT_W-1:0] pcm,
  output logic                  pcm_valid,
  output logic                  overrun
);
  localparam int W  = cic_acc_width(ORDER, DEC);
  localparam int CW = $clog2(DEC);
  logic [W-1:0] integ_q [N_CH][ORDER];
  logic [W-1:0] integ_d [N_CH][ORDER];
  logic [N_CH*W-1:0] last;
  logic [CW-1:0] cnt_q, cnt_d;
  logic overrun_q, overrun_d, tick, busy;
  // Integrators wrap modulo 2^W; the comb differences recover the exact result.
  always_comb begin
    integ_d = integ_q;
    last = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (pdm_valid) begin
        integ_d[c][0] = integ_q[c][0] + ((pdm[c] == PDM_POS_BIT) ? W'(1) : '1);
        for (int k = 1; k < ORDER; k++) integ_d[c][k] = integ_q[c][k] + integ_d[c][k-1];
      end
      last[c*W +: W] = integ_d[c][ORDER-1];
    end
    tick = pdm_valid && cnt_q == CW'(DEC - 1);
    cnt_d = pdm_valid ? cnt_q + 1'b1 : cnt_q;
    overrun_d = overrun_q | (tick & busy);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      integ_q <= '{default: '0};
      cnt_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      integ_q <= integ_d;
      cnt_q <= cnt_d;
      overrun_q <= overrun_d;
    end
  end
  assign overrun = overrun_q;
  cic_comb_engine #(.N_CH(N_CH), .ORDER(ORDER), .OUT_W(OUT_W), .W(W)) u_comb (
    .clk(clk),
    .reset(reset),
    .tick(tick),
    .last(last),
    .busy(busy),
    .pcm(pcm),
    .pcm_valid(pcm_valid)
  );
endmodule

// File: tb/tb_pdm_cic_decimator.sv
// tb_pdm_cic_decimator: vector table, random stimulus vs impulse-response model, overrun, rounding and reset-in-COMB sequences.
module tb_pdm_cic_decimator;
  localparam int NCH = 2, ORD = 4, DC = 64, OW = 16, SH = 9;
  localparam int HL = ORD * (DC - 1) + 1;
  logic clk = 0;
  always #5 clk = ~clk;

  logic rst_a = 1, pv_a = 0, pcm_valid_a, overrun_a;
  logic [1:0] pdm_a = '0;
  logic [31:0] pcm_a;
  logic rst_b = 1, pv_b = 0, pcm_valid_b, overrun_b;
  logic [3:0] pdm_b = '0;
  logic [31:0] pcm_b;
  logic rst_c = 1, pv_c = 0, pcm_valid_c, overrun_c;
  logic [0:0] pdm_c = '0;
  logic [1:0] pcm_c;

  pdm_cic_decimator dut_a (.clk(clk), .reset(rst_a), .pdm(pdm_a), .pdm_valid(pv_a),
    .pcm(pcm_a), .pcm_valid(pcm_valid_a), .overrun(overrun_a));
  pdm_cic_decimator #(.N_CH(4), .ORDER(4), .DEC(4), .OUT_W(8)) dut_b (.clk(clk), .reset(rst_b),
    .pdm(pdm_b), .pdm_valid(pv_b), .pcm(pcm_b), .pcm_valid(pcm_valid_b), .overrun(overrun_b));
  pdm_cic_decimator #(.N_CH(1), .ORDER(1), .DEC(8), .OUT_W(2)) dut_c (.clk(clk), .reset(rst_c),
    .pdm(pdm_c), .pdm_valid(pv_c), .pcm(pcm_c), .pcm_valid(pcm_valid_c), .overrun(overrun_c));

  int tests = 0, fails = 0;
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: R is the input convolved with the ORDER-fold boxcar of length DEC, sampled at each tick.
  int h [HL];
  int hist [NCH][$];
  typedef struct {int v0; int v1; int due;} exp_t;
  exp_t expq [$];
  int ecnt = 0, last_tick = 0, last_pv = 0, last_gap = 0, last0 = 0, last1 = 0;

  function automatic int ref_r(input int c);
    int n = hist[c].size();
    int r = 0;
    for (int k = 0; k < HL && k < n; k++) r += h[k] * hist[c][n-1-k];
    return r;
  endfunction
  function automatic int scale(input int r, input int s, input int ow);
    int v;
`ifdef CIC_ROUND_EN
    v = (r + (1 << (s - 1))) >>> s;
`else
    v = r >>> s;
`endif
    if (v > (1 << (ow - 1)) - 1) v = (1 << (ow - 1)) - 1;
    if (v < -(1 << (ow - 1))) v = -(1 << (ow - 1));
    return v;
  endfunction

  initial forever begin
    exp_t e;
    @(posedge clk);
    ecnt++;
    if (rst_a) begin
      for (int c = 0; c < NCH; c++) hist[c].delete();
      expq.delete();
    end else if (pv_a) begin
      for (int c = 0; c < NCH; c++) hist[c].push_back(pdm_a[c] ? 1 : -1);
      if (hist[0].size() % DC == 0) begin
        e.v0 = scale(ref_r(0), SH, OW);
        e.v1 = scale(ref_r(1), SH, OW);
        e.due = ecnt + NCH;
        expq.push_back(e);
        last_tick = ecnt;
      end
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (pcm_valid_a) begin
      if (expq.size() == 0) chk("unexpected_pcm_valid", 1, 0);
      else begin
        e = expq.pop_front();
        chk("latency", ecnt, e.due);
        chk("pcm_ch0", $signed(pcm_a[15:0]), e.v0);
        chk("pcm_ch1", $signed(pcm_a[31:16]), e.v1);
      end
      last_gap = ecnt - last_pv;
      last_pv = ecnt;
      last0 = $signed(pcm_a[15:0]);
      last1 = $signed(pcm_a[31:16]);
    end
  end

  task automatic reset_a();
    rst_a = 1;
    pv_a = 0;
    step();
    chk("rst_pcm", int'(pcm_a), 0);
    chk("rst_valid", pcm_valid_a, 0);
    chk("rst_overrun", overrun_a, 0);
    step();
    rst_a = 0;
  endtask
  // mode: 0 const 0, 1 const 1, 2 alternating, 3 random density; vper 0 = random pdm_valid
  task automatic run_a(input int m0, input int m1, input int vper, input int cycles);
    bit alt = 1;
    int d0 = $urandom_range(0, 100), d1 = $urandom_range(0, 100);
    for (int i = 0; i < cycles; i++) begin
      pv_a = (vper == 0) ? ($urandom_range(0, 2) != 0) : (i % vper == 0);
      pdm_a[0] = m0 == 2 ? alt : m0 == 3 ? ($urandom_range(0, 99) < d0) : m0[0];
      pdm_a[1] = m1 == 2 ? alt : m1 == 3 ? ($urandom_range(0, 99) < d1) : m1[0];
      if (pv_a) alt = !alt;
      step();
    end
    pv_a = 0;
    repeat (4) step();
  endtask

  typedef struct {int m0; int m1; int vper; int e0; int e1;} vec_t;
  vec_t vt [5];
  int tmp [HL];
  int np, nc, t0, guard;
  localparam int EXP_C =
`ifdef CIC_ROUND_EN
    1;
`else
    0;
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    h = '{default: 0};
    h[0] = 1;
    for (int o = 0; o < ORD; o++) begin
      tmp = '{default: 0};
      for (int i = 0; i < HL; i++)
        for (int j = 0; j < DC && i + j < HL; j++) tmp[i+j] += h[i];
      h = tmp;
    end
    vt[0] = '{1, 1, 1, 32767, 32767};
    vt[1] = '{0, 0, 1, -32768, -32768};
    vt[2] = '{2, 1, 1, 0, 32767};
    vt[3] = '{1, 2, 2, 32767, 0};
    vt[4] = '{2, 0, 1, 0, -32768};
    #1;
    for (int v = 0; v < 5; v++) begin
      reset_a();
      run_a(vt[v].m0, vt[v].m1, vt[v].vper, 8 * DC * vt[v].vper);
      chk("vec_ch0", last0, vt[v].e0);
      chk("vec_ch1", last1, vt[v].e1);
      chk("vec_period", last_gap, DC * vt[v].vper);
    end
    for (int r = 0; r < 3; r++) begin
      reset_a();
      run_a(3, 3, 0, 12 * DC);
    end
    chk("overrun_a_clear", overrun_a, 0);

    reset_a();
    pv_a = 1;
    pdm_a = 2'b11;
    t0 = last_tick;
    guard = 0;
    while (last_tick == t0 && guard < 200) begin step(); guard++; end
    chk("tick_seen", int'(last_tick != t0), 1);
    rst_a = 1;
    step();
    rst_a = 0;
    chk("midcomb_pcm", int'(pcm_a), 0);
    for (int i = 0; i < 4; i++) begin
      chk("midcomb_no_valid", pcm_valid_a, 0);
      step();
    end
    run_a(1, 1, 1, 6 * DC);

    rst_b = 1;
    step();
    chk("ovr_reset", overrun_b, 0);
    step();
    rst_b = 0;
    pv_b = 1;
    pdm_b = '1;
    np = 0;
    for (int e = 1; e <= 50; e++) begin
      if (e == 41) pv_b = 0;
      step();
      np += int'(pcm_valid_b);
      if (e == 7) chk("ovr_before_2nd_tick", overrun_b, 0);
      if (e == 8) chk("ovr_at_2nd_tick", overrun_b, 1);
    end
    chk("ovr_frames", np, 5);
    chk("ovr_sticky", overrun_b, 1);
    rst_b = 1;
    step();
    rst_b = 0;
    chk("ovr_cleared", overrun_b, 0);

    rst_c = 1;
    step();
    step();
    rst_c = 0;
    pv_c = 1;
    nc = 0;
    for (int i = 0; i < 96; i++) begin
      pdm_c[0] = (i % 8) < 5;
      step();
      if (i >= 24 && pcm_valid_c) begin
        chk("round_pcm", $signed(pcm_c), EXP_C);
        nc++;
      end
    end
    chk("round_frames", nc, 9);
    chk("round_overrun", overrun_c, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
